// File: rtl/backend_tx_if.sv
// Stream-master and BRAM read-port bundle for backend_tx.
interface backend_tx_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 6
);
  logic                  bram_enb;
  logic [ADDR_W-1:0]     bram_addrb;
  logic [DATA_W-1:0]     bram_doutb;
  logic [DATA_W-1:0]     m_axis_tdata;
  logic [DATA_W/8-1:0]   m_axis_tkeep;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;

  modport master (
    output bram_enb, bram_addrb,
    input  bram_doutb,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  bram_enb, bram_addrb,
    output bram_doutb,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/backend_tx.sv
// Reads a packet buffer from BRAM port B and streams it out as AXI-Stream.
// Optional packet/byte counters are enabled with BACKEND_TX_STATS_EN.
module backend_tx #(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 6,
  parameter int RD_LAT  = 2,
  parameter int MAX_LEN = 1514
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic [15:0] length_be,
  output logic        finish,
  output logic        err,
  output logic        busy,
`ifdef BACKEND_TX_STATS_EN
  output logic [31:0] pkt_count,
  output logic [31:0] byte_count,
`endif
  backend_tx_if.master bus
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int REM_W  = $clog2(KEEP_W);
  localparam int DEPTH  = RD_LAT + 2;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BEAT_W = ADDR_W + 1;
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, CHECK, STREAM, DONE} state_t;

  state_t              state;
  logic [15:0]         len;
  logic [BEAT_W-1:0]   beats;
  logic [BEAT_W-1:0]   issued;
  logic [BEAT_W-1:0]   popped;
  logic [REM_W-1:0]    rem;
  logic [RD_LAT-1:0]   vld;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W:0]      occupancy;
  logic                issue;
  logic                push;
  logic                pop;
  logic                valid;
  logic                full;
  logic                last_beat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Reads already in the BRAM pipeline reserve FIFO space, so a read is only
  // issued when its data is guaranteed a slot on return.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(vld[i]);
    end
  end

  assign occupancy = {1'b0, inflight} + {1'b0, count};
  assign issue     = (state == STREAM) && (issued < beats) &&
                     (occupancy < (CNT_W + 1)'(DEPTH));
  assign push      = vld[RD_LAT-1];
  assign valid     = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = valid && bus.m_axis_tready;
  assign last_beat = (popped == beats - BEAT_W'(1));

  assign bus.bram_enb      = issue;
  assign bus.bram_addrb    = issue ? issued[ADDR_W-1:0] : '0;
  assign bus.m_axis_tvalid = valid;
  assign bus.m_axis_tdata  = valid ? mem[rd_ptr] : '0;
  assign bus.m_axis_tlast  = valid && last_beat;
  assign bus.m_axis_tkeep  = !valid ? '0 :
                             (last_beat && rem != '0) ? ~({KEEP_W{1'b1}} << rem) :
                             {KEEP_W{1'b1}};

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= bus.bram_doutb;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state  <= IDLE;
      len    <= '0;
      beats  <= '0;
      rem    <= '0;
      issued <= '0;
      popped <= '0;
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      finish <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
`ifdef BACKEND_TX_STATS_EN
      pkt_count  <= '0;
      byte_count <= '0;
`endif
    end else begin
      finish <= 1'b0;
      err    <= 1'b0;
      vld[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (issue) issued <= issued + BEAT_W'(1);
      if (pop)   popped <= popped + BEAT_W'(1);

      case (state)
        IDLE: begin
          if (start) begin
            len   <= length_be;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (len == 16'd0 || len > MAX_LEN_W) begin
            finish <= 1'b1;
            err    <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            beats  <= BEAT_W'((len + 16'd31) >> 5);
            rem    <= len[REM_W-1:0];
            issued <= '0;
            popped <= '0;
            state  <= STREAM;
          end
        end
        STREAM: begin
          if (pop && last_beat) begin
            finish <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
`ifdef BACKEND_TX_STATS_EN
          pkt_count  <= pkt_count + 32'd1;
          byte_count <= byte_count + 32'(len);
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_no_overflow:  assert property (@(posedge aclk) disable iff (areset) !(push && full));
  fifo_no_underflow: assert property (@(posedge aclk) disable iff (areset) !(pop && !valid));

endmodule

// File: tb/tb_backend_tx.sv
// Directed self-checking bench for backend_tx with a BRAM read-latency model.
module tb_backend_tx;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 6;
  localparam int RD_LAT = 2;
  localparam int KEEP_W = DATA_W / 8;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic [15:0] length_be;
  logic        finish;
  logic        err;
  logic        busy;
  logic        tready;
`ifdef BACKEND_TX_STATS_EN
  logic [31:0] pkt_count;
  logic [31:0] byte_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  backend_tx_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  backend_tx #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_LEN(1514)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .start     (start),
    .length_be (length_be),
    .finish    (finish),
    .err       (err),
    .busy      (busy),
`ifdef BACKEND_TX_STATS_EN
    .pkt_count (pkt_count),
    .byte_count(byte_count),
`endif
    .bus       (bus)
  );

  always #5 aclk = ~aclk;

  assign bus.m_axis_tready = tready;

  // BRAM port B model: data appears RD_LAT cycles after the enable.
  logic [DATA_W-1:0] bram [64];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge aclk) begin
    rd_pipe[0] <= bus.bram_enb ? bram[bus.bram_addrb] : {8{32'hDEADBEEF}};
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.bram_doutb = rd_pipe[RD_LAT-1];

  function automatic logic [DATA_W-1:0] word(input int i);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = {8'(i), 8'(k), 16'hA55A};
    return w;
  endfunction

  logic [DATA_W-1:0] got_data [$];
  logic [KEEP_W-1:0] got_keep [$];
  logic              got_last [$];
  int                got_addr [$];
  int first_valid, last_acc, finish_cyc, finish_cnt, err_cnt, err_fin;
  int valid_cnt, stall_viol, max_out;

  // Drives one start and records everything the DUT does until a few cycles after finish.
  task automatic run_pkt(input logic [15:0] len, input bit rand_ready, input bit dup_start);
    int outstanding;
    bit held;
    logic [DATA_W-1:0] hd;
    logic [KEEP_W-1:0] hk;
    logic hl;
    got_data.delete(); got_keep.delete(); got_last.delete(); got_addr.delete();
    first_valid = -1; last_acc = -1; finish_cyc = -1; finish_cnt = 0; err_cnt = 0; err_fin = 0;
    valid_cnt = 0; stall_viol = 0; max_out = 0; outstanding = 0;
    held = 1'b0; hd = '0; hk = '0; hl = 1'b0;
    @(posedge aclk); #1;
    start = 1'b1;
    length_be = len;
    tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge aclk);
      if (bus.bram_enb) begin
        got_addr.push_back(int'(bus.bram_addrb));
        outstanding++;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (held && (!bus.m_axis_tvalid || bus.m_axis_tdata !== hd ||
                   bus.m_axis_tkeep !== hk || bus.m_axis_tlast !== hl)) stall_viol++;
      held = 1'b0;
      if (bus.m_axis_tvalid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = c;
        if (tready) begin
          got_data.push_back(bus.m_axis_tdata);
          got_keep.push_back(bus.m_axis_tkeep);
          got_last.push_back(bus.m_axis_tlast);
          last_acc = c;
          outstanding--;
        end else begin
          held = 1'b1;
          hd = bus.m_axis_tdata;
          hk = bus.m_axis_tkeep;
          hl = bus.m_axis_tlast;
        end
      end
      if (err) err_cnt++;
      if (finish) begin
        finish_cnt++;
        if (err) err_fin++;
        if (finish_cyc < 0) finish_cyc = c;
      end
      if (finish_cyc >= 0 && c >= finish_cyc + 3) break;
      @(posedge aclk); #1;
      start = dup_start && (c == 0);
      if (dup_start && c == 0) length_be = 16'd60;
      if (rand_ready) tready = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    tready = 1'b1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    start = 1'b0;
    length_be = '0;
    tready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    tests_run++;
    if ({finish, err, busy} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000", {finish, err, busy});
    end
    tests_run++;
    if ({bus.bram_enb, bus.bram_addrb} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_bram: got enb=%b addr=%0d expected 0", bus.bram_enb, bus.bram_addrb);
    end
    tests_run++;
    if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_stream: got valid=%b last=%b keep=%h expected 0",
               bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tkeep);
    end
`ifdef BACKEND_TX_STATS_EN
    tests_run++;
    if ({pkt_count, byte_count} !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_stats: got pkt=%0d bytes=%0d expected 0", pkt_count, byte_count);
    end
`endif
    @(posedge aclk); #1;
    areset = 1'b0;
    tready = 1'b1;
  endtask

  task automatic test_stream_lengths();
    int          t_len   [4] = '{60, 64, 32, 1514};
    int          t_beats [4] = '{2, 2, 1, 48};
    logic [31:0] t_keep  [4] = '{32'h0FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h000003FF};
    for (int t = 0; t < 4; t++) begin
      run_pkt(16'(t_len[t]), 1'b0, 1'b0);
      tests_run++;
      if (got_data.size() !== t_beats[t]) begin
        tests_failed++;
        $display("[TB] FAIL len%0d_beats: got %0d expected %0d", t_len[t], got_data.size(), t_beats[t]);
      end
      for (int k = 0; k < got_data.size() && k < t_beats[t]; k++) begin
        tests_run++;
        if (got_data[k] !== word(k) || got_last[k] !== (k == t_beats[t] - 1) ||
            got_keep[k] !== ((k == t_beats[t] - 1) ? t_keep[t] : 32'hFFFFFFFF)) begin
          tests_failed++;
          $display("[TB] FAIL len%0d_beat%0d: got keep=%h last=%b data=%h expected keep=%h last=%b data=%h",
                   t_len[t], k, got_keep[k], got_last[k], got_data[k],
                   (k == t_beats[t] - 1) ? t_keep[t] : 32'hFFFFFFFF, k == t_beats[t] - 1, word(k));
        end
      end
      tests_run++;
      if (got_addr.size() !== t_beats[t]) begin
        tests_failed++;
        $display("[TB] FAIL len%0d_reads: got %0d expected %0d", t_len[t], got_addr.size(), t_beats[t]);
      end
      for (int k = 0; k < got_addr.size() && k < t_beats[t]; k++) begin
        tests_run++;
        if (got_addr[k] !== k) begin
          tests_failed++;
          $display("[TB] FAIL len%0d_addr%0d: got %0d expected %0d", t_len[t], k, got_addr[k], k);
        end
      end
      tests_run++;
      if (first_valid !== 3 + RD_LAT || last_acc !== 4 + t_beats[t] || finish_cyc !== 5 + t_beats[t]) begin
        tests_failed++;
        $display("[TB] FAIL len%0d_timing: got valid@%0d last@%0d finish@%0d expected %0d %0d %0d",
                 t_len[t], first_valid, last_acc, finish_cyc, 3 + RD_LAT, 4 + t_beats[t], 5 + t_beats[t]);
      end
      tests_run++;
      if (finish_cnt !== 1 || err_cnt !== 0) begin
        tests_failed++;
        $display("[TB] FAIL len%0d_finish: got finish=%0d err=%0d expected 1 0", t_len[t], finish_cnt, err_cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    int nlast;
    run_pkt(16'd1514, 1'b1, 1'b0);
    tests_run++;
    if (got_data.size() !== 48) begin
      tests_failed++;
      $display("[TB] FAIL bp_beats: got %0d expected 48", got_data.size());
    end
    nlast = 0;
    for (int k = 0; k < got_data.size() && k < 48; k++) begin
      if (got_last[k]) nlast++;
      tests_run++;
      if (got_data[k] !== word(k)) begin
        tests_failed++;
        $display("[TB] FAIL bp_data%0d: got %h expected %h", k, got_data[k], word(k));
      end
    end
    tests_run++;
    if (got_data.size() == 48 && (nlast !== 1 || got_last[47] !== 1'b1 || got_keep[47] !== 32'h000003FF)) begin
      tests_failed++;
      $display("[TB] FAIL bp_last: got tlast count=%0d keep=%h expected 1 000003ff", nlast, got_keep[47]);
    end
    tests_run++;
    if (stall_viol !== 0) begin
      tests_failed++;
      $display("[TB] FAIL bp_stable: got %0d changes during stall expected 0", stall_viol);
    end
    tests_run++;
    if (max_out !== 4) begin
      tests_failed++;
      $display("[TB] FAIL bp_throttle: got peak outstanding %0d expected 4", max_out);
    end
    tests_run++;
    if (got_addr.size() !== 48) begin
      tests_failed++;
      $display("[TB] FAIL bp_reads: got %0d expected 48", got_addr.size());
    end
    tests_run++;
    if (finish_cnt !== 1 || err_cnt !== 0) begin
      tests_failed++;
      $display("[TB] FAIL bp_finish: got finish=%0d err=%0d expected 1 0", finish_cnt, err_cnt);
    end
  endtask

  task automatic test_reject();
    int t_len [2] = '{0, 1515};
    for (int t = 0; t < 2; t++) begin
      run_pkt(16'(t_len[t]), 1'b0, t == 0);
      tests_run++;
      if (finish_cyc !== 2 || finish_cnt !== 1) begin
        tests_failed++;
        $display("[TB] FAIL rej%0d_finish: got finish@%0d count=%0d expected @2 count=1",
                 t_len[t], finish_cyc, finish_cnt);
      end
      tests_run++;
      if (err_fin !== 1 || err_cnt !== 1) begin
        tests_failed++;
        $display("[TB] FAIL rej%0d_err: got err_with_finish=%0d err=%0d expected 1 1",
                 t_len[t], err_fin, err_cnt);
      end
      tests_run++;
      if (valid_cnt !== 0 || got_addr.size() !== 0) begin
        tests_failed++;
        $display("[TB] FAIL rej%0d_quiet: got tvalid=%0d reads=%0d expected 0 0",
                 t_len[t], valid_cnt, got_addr.size());
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int  n_acc;
    int  fin;
    bit  reached;
    n_acc = 0;
    fin = 0;
    reached = 1'b0;
    @(posedge aclk); #1;
    start = 1'b1;
    length_be = 16'd1514;
    tready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge aclk);
      if (finish) fin++;
      if (bus.m_axis_tvalid && tready) n_acc++;
      if (n_acc == 10) begin
        reached = 1'b1;
        break;
      end
      @(posedge aclk); #1;
      start = 1'b0;
    end
    tests_run++;
    if (!reached) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_reach: got %0d beats expected 10", n_acc);
    end
    @(posedge aclk); #1;
    start = 1'b0;
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    tests_run++;
    if ({finish, err, busy, bus.bram_enb, bus.bram_addrb} !== '0 ||
        {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_outputs: got finish=%b busy=%b enb=%b valid=%b last=%b expected all 0",
               finish, busy, bus.bram_enb, bus.m_axis_tvalid, bus.m_axis_tlast);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      if (finish || bus.m_axis_tvalid) fin++;
    end
    tests_run++;
    if (fin !== 0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_nofinish: got %0d finish/tvalid events expected 0", fin);
    end
    run_pkt(16'd60, 1'b0, 1'b0);
    tests_run++;
    if (got_data.size() !== 2 || finish_cyc !== 7 || finish_cnt !== 1) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_next: got beats=%0d finish@%0d count=%0d expected 2 @7 1",
               got_data.size(), finish_cyc, finish_cnt);
    end
    tests_run++;
    if (got_data.size() == 2 && (got_data[0] !== word(0) || got_data[1] !== word(1) ||
                                 got_keep[1] !== 32'h0FFFFFFF || got_last[1] !== 1'b1)) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_data: got keep1=%h last1=%b expected 0fffffff 1", got_keep[1], got_last[1]);
    end
`ifdef BACKEND_TX_STATS_EN
    tests_run++;
    if (pkt_count !== 32'd1 || byte_count !== 32'd60) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_stats: got pkt=%0d bytes=%0d expected 1 60", pkt_count, byte_count);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) bram[i] = word(i);
    areset = 1'b1;
    start = 1'b0;
    length_be = '0;
    tready = 1'b0;
    test_reset();
    test_stream_lengths();
    test_backpressure();
    test_reject();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
